// File: rtl/split.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | split: word-to-chunk serializer, least significant chunk first.          |
// | Optional SPLIT_PREFETCH_EN adds a one-word holding buffer.               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module split #(
  parameter int DATAW_IN  = 32,
  parameter int DATAW_OUT = 8,
  parameter int SPLIT_NUM = 4,
  parameter int SPLIT_LEN = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATAW_IN-1:0]  din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic [DATAW_OUT-1:0] dout,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic                 busy
);

  localparam logic [0:0] c_st_idle = 1'b0;
  localparam logic [0:0] c_st_send = 1'b1;
  localparam logic [SPLIT_LEN-1:0] c_last_idx = SPLIT_LEN'(SPLIT_NUM - 1);

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [SPLIT_LEN-1:0] r_idx;
  logic [SPLIT_LEN-1:0] w_idx_nxt;
  logic [DATAW_IN-1:0]  r_word;
  logic [DATAW_IN-1:0]  w_word_nxt;
  logic [DATAW_OUT-1:0] r_dout;
  logic [DATAW_OUT-1:0] w_chunk_nxt;
  logic                 w_din_hs;
  logic                 w_dout_hs;
  logic                 w_last_hs;
  logic                 w_buf_full;

  assign w_din_hs  = din_valid & din_ready;
  assign w_dout_hs = dout_valid & dout_ready;
  assign w_last_hs = w_dout_hs & (r_idx == c_last_idx);
  assign dout      = r_dout;

`ifdef SPLIT_PREFETCH_EN
  logic [DATAW_IN-1:0] r_buf;
  logic                r_buf_full;

  assign w_buf_full = r_buf_full;

  // The buffer only fills during SEND; in IDLE din goes straight to the word register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_buf      <= '0;
      r_buf_full <= 1'b0;
    end else if (w_last_hs && r_buf_full) begin
      if (w_din_hs) begin
        r_buf <= din;
      end else begin
        r_buf_full <= 1'b0;
      end
    end else if (w_din_hs && (r_state == c_st_send) && !w_last_hs) begin
      r_buf      <= din;
      r_buf_full <= 1'b1;
    end
  end
`else
  assign w_buf_full = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_din_hs) begin
          w_state_nxt = c_st_send;
        end
      end
      c_st_send: begin
        if (w_last_hs) begin
`ifdef SPLIT_PREFETCH_EN
          w_state_nxt = (w_buf_full || w_din_hs) ? c_st_send : c_st_idle;
`else
          w_state_nxt = c_st_idle;
`endif
        end
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // Output logic
  always_comb begin
    din_ready  = 1'b1;
    dout_valid = 1'b0;
    busy       = w_buf_full;
    case (r_state)
      c_st_idle: begin
        din_ready  = 1'b1;
        dout_valid = 1'b0;
      end
      c_st_send: begin
`ifdef SPLIT_PREFETCH_EN
        din_ready  = ~w_buf_full;
`else
        din_ready  = 1'b0;
`endif
        dout_valid = 1'b1;
        busy       = 1'b1;
      end
      default: begin
        din_ready  = 1'b0;
        dout_valid = 1'b0;
      end
    endcase
  end

  // Datapath next values: word register and chunk index
  always_comb begin
    w_word_nxt = r_word;
    w_idx_nxt  = r_idx;
    case (r_state)
      c_st_idle: begin
        if (w_din_hs) begin
          w_word_nxt = din;
          w_idx_nxt  = '0;
        end
      end
      c_st_send: begin
        if (w_last_hs) begin
          w_idx_nxt = '0;
`ifdef SPLIT_PREFETCH_EN
          if (w_buf_full) begin
            w_word_nxt = r_buf;
          end else if (w_din_hs) begin
            w_word_nxt = din;
          end
`endif
        end else if (w_dout_hs) begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: begin
        w_word_nxt = r_word;
        w_idx_nxt  = '0;
      end
    endcase
  end

  // dout is registered: select the chunk that will be current after this edge.
  always_comb begin
    w_chunk_nxt = '0;
    for (int k = 0; k < SPLIT_NUM; k++) begin
      if (w_idx_nxt == SPLIT_LEN'(k)) begin
        w_chunk_nxt = w_word_nxt[k*DATAW_OUT +: DATAW_OUT];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_word <= '0;
      r_idx  <= '0;
      r_dout <= '0;
    end else begin
      r_word <= w_word_nxt;
      r_idx  <= w_idx_nxt;
      r_dout <= (w_state_nxt == c_st_send) ? w_chunk_nxt : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_split.sv
`default_nettype none
// Directed self-checking bench for split (base build or SPLIT_PREFETCH_EN).
module tb_split;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        din_valid;
  logic        din_ready;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  split #(
    .DATAW_IN (32),
    .DATAW_OUT(8),
    .SPLIT_NUM(4),
    .SPLIT_LEN(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; din = 32'h0; din_valid = 1'b0; dout_ready = 1'b0;
    step(); step();
    checks++;
    if (dout_valid !== 1'b0 || dout !== 8'h00) begin
      errors++; $display("FAIL reset_dout valid=%b dout=%h expected valid=0 dout=00", dout_valid, dout);
    end
    checks++;
    if (din_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_flags din_ready=%b busy=%b expected 1 0", din_ready, busy);
    end
    rst = 1'b1;
    step();
    checks++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release valid=%b ready=%b busy=%b expected 0 1 0", dout_valid, din_ready, busy);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp [4];
    exp[0] = 8'hEF; exp[1] = 8'hBE; exp[2] = 8'hAD; exp[3] = 8'hDE;
    din = 32'hDEADBEEF; din_valid = 1'b1; dout_ready = 1'b1;
    step();
    din_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== exp[k]) begin
        errors++; $display("FAIL basic_chunk%0d valid=%b dout=%h expected valid=1 dout=%h", k, dout_valid, dout, exp[k]);
      end
      step();
    end
    checks++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_idle valid=%b ready=%b busy=%b expected 0 1 0", dout_valid, din_ready, busy);
    end
  endtask

  task automatic test_stall();
    logic [7:0] exp [4];
    logic       pat [7];
    logic [7:0] got [$];
    logic [7:0] prev_dout;
    logic       prev_held;
    logic       stable_ok;
    exp[0] = 8'hEF; exp[1] = 8'hBE; exp[2] = 8'hAD; exp[3] = 8'hDE;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1; pat[4] = 0; pat[5] = 1; pat[6] = 1;
    din = 32'hDEADBEEF; din_valid = 1'b1; dout_ready = 1'b0;
    step();
    din_valid = 1'b0;
    prev_held = 1'b0; prev_dout = 8'h00; stable_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (prev_held && (dout_valid !== 1'b1 || dout !== prev_dout)) stable_ok = 1'b0;
      dout_ready = (i < 7) ? pat[i] : 1'b1;
      if (dout_valid === 1'b1 && dout_ready) got.push_back(dout);
      prev_held = (dout_valid === 1'b1) && !dout_ready;
      prev_dout = dout;
      step();
    end
    checks++;
    if (!stable_ok) begin
      errors++; $display("FAIL stall_stable dout changed while stalled, expected held value");
    end
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL stall_count got %0d chunks expected 4", got.size());
    end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp[k]) begin
        errors++; $display("FAIL stall_chunk%0d got %h expected %h", k, got[k], exp[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [2];
    logic [7:0]  got [$];
    int          widx;
    int          gaps;
    int          exp_gaps;
    logic        hs_in;
    words[0] = 32'h03020100; words[1] = 32'h07060504;
`ifdef SPLIT_PREFETCH_EN
    exp_gaps = 0;
`else
    exp_gaps = 1;
`endif
    widx = 0; gaps = 0;
    din = words[0]; din_valid = 1'b1; dout_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (got.size() >= 1 && got.size() < 8 && dout_valid !== 1'b1) gaps++;
      hs_in = din_valid && (din_ready === 1'b1);
      if (dout_valid === 1'b1) got.push_back(dout);
      step();
      if (hs_in) begin
        widx++;
        if (widx < 2) din = words[widx];
        else din_valid = 1'b0;
      end
    end
    checks++;
    if (got.size() != 8) begin
      errors++; $display("FAIL b2b_count got %0d chunks expected 8", got.size());
    end
    for (int k = 0; k < 8 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== 8'(k)) begin
        errors++; $display("FAIL b2b_chunk%0d got %h expected %h", k, got[k], 8'(k));
      end
    end
    checks++;
    if (gaps != exp_gaps) begin
      errors++; $display("FAIL b2b_bubbles got %0d expected %0d", gaps, exp_gaps);
    end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp [4];
    int         extra;
    din = 32'h11223344; din_valid = 1'b1; dout_ready = 1'b1;
    step();
    din_valid = 1'b0;
    step(); step();
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'h22) begin
      errors++; $display("FAIL rstmid_pre valid=%b dout=%h expected 1 22", dout_valid, dout);
    end
    rst = 1'b0;
    step();
    rst = 1'b1;
    checks++;
    if (dout_valid !== 1'b0 || dout !== 8'h00 || busy !== 1'b0 || din_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_after valid=%b dout=%h busy=%b ready=%b expected 0 00 0 1", dout_valid, dout, busy, din_ready);
    end
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (dout_valid !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL rstmid_nochunks got %0d stray valid cycles expected 0", extra);
    end
    din = 32'hA5A5A5A5; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (dout_valid !== 1'b1 || dout !== 8'hA5) begin
        errors++; $display("FAIL rstmid_new%0d valid=%b dout=%h expected 1 a5", k, dout_valid, dout);
      end
      step();
    end
    checks++;
    if (dout_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_end valid=%b busy=%b expected 0 0", dout_valid, busy);
    end
    exp[0] = 8'h00;
  endtask

  task automatic test_ignored_pulse();
`ifndef SPLIT_PREFETCH_EN
    logic [7:0] exp [4];
    logic [7:0] got [$];
    exp[0] = 8'hEF; exp[1] = 8'hCD; exp[2] = 8'hAB; exp[3] = 8'h89;
    din = 32'h89ABCDEF; din_valid = 1'b1; dout_ready = 1'b0;
    step();
    din = 32'h55555555; din_valid = 1'b1;
    checks++;
    if (din_ready !== 1'b0) begin
      errors++; $display("FAIL pulse_ready din_ready=%b expected 0", din_ready);
    end
    step();
    din_valid = 1'b0; dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (dout_valid === 1'b1) got.push_back(dout);
      step();
    end
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL pulse_count got %0d chunks expected 4", got.size());
    end
    for (int k = 0; k < 4 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp[k]) begin
        errors++; $display("FAIL pulse_chunk%0d got %h expected %h", k, got[k], exp[k]);
      end
    end
`endif
  endtask

  task automatic test_loopback();
    logic [31:0] sent [$];
    logic [31:0] acc;
    logic [31:0] src;
    int          nchunk;
    int          nsent;
    int          nrecv;
    int          bad;
    logic        hs_in;
    acc = 32'h0; nchunk = 0; nsent = 0; nrecv = 0; bad = 0;
    din = $urandom; din_valid = 1'b1;
    for (int i = 0; i < 5000 && nrecv < 100; i++) begin
      dout_ready = ($urandom_range(0, 3) != 0);
      hs_in = din_valid && (din_ready === 1'b1);
      if (hs_in) sent.push_back(din);
      if (dout_valid === 1'b1 && dout_ready) begin
        acc = {dout, acc[31:8]};
        nchunk++;
        if (nchunk == 4) begin
          nchunk = 0;
          src = (sent.size() > 0) ? sent.pop_front() : 32'hxxxxxxxx;
          if (acc !== src) begin
            bad++;
            if (bad < 4) $display("FAIL loopback_word%0d got %h expected %h", nrecv, acc, src);
          end
          nrecv++;
        end
      end
      step();
      if (hs_in) begin
        nsent++;
        din = $urandom;
        din_valid = (nsent < 100);
      end
    end
    din_valid = 1'b0;
    checks++;
    if (nrecv != 100) begin
      errors++; $display("FAIL loopback_count got %0d words expected 100", nrecv);
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL loopback_data got %0d bad words expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_reset_mid_word();
    test_ignored_pulse();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/split.md
Name: split

Overview:
- Word-to-byte serializer: accepts a DATAW_IN-bit word and emits it as CONCAT-compatible DATAW_OUT-bit chunks, least significant chunk first.
- Sits on the transmit path between the core's output port and the UART transmitter.
- It is the inverse of the byte-concatenating receive path; a word split here and re-concatenated there round-trips bit-exact.
- Valid/ready handshake on both sides.

Parameters:
- DATAW_IN, 32, input word width
- DATAW_OUT, 8, output chunk width
- SPLIT_NUM, 4, chunks per word; DATAW_IN = DATAW_OUT*SPLIT_NUM required
- SPLIT_LEN, 2, chunk index width; clog2(SPLIT_NUM), min 1

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset, synchronous, active-low
- din  input  DATAW_IN  word to transmit
- din_valid  input  1  din holds a word
- din_ready  output  1  block can accept a word this cycle
- dout  output  DATAW_OUT  current chunk
- dout_valid  output  1  dout holds a chunk
- dout_ready  input  1  downstream (UART tx) accepts chunk this cycle
- busy  output  1  a word is being split or is buffered

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, idx=0, word register=0.
  - dout=0, dout_valid=0, din_ready=1, busy=0.
  - Any in-flight or buffered word is discarded; no partial chunk is emitted after reset.
- Handshakes: transfer occurs when valid&&ready at posedge. din_valid is ignored while din_ready=0. dout_ready is ignored while dout_valid=0.
- Output stability: dout_valid, once high, stays high with dout stable until accepted.
- FSM, 2 states:
  - IDLE:
    - din_ready=1, dout_valid=0.
    - On din handshake: latch din, idx<=0, go SEND.
  - SEND:
    - dout_valid=1; dout=word[idx*DATAW_OUT +: DATAW_OUT] (registered).
    - On dout handshake with idx<SPLIT_NUM-1: idx<=idx+1.
    - On dout handshake with idx==SPLIT_NUM-1: idx<=0, go IDLE (base build).
- Latency: first chunk valid 1 cycle after din handshake. With dout_ready held high, chunk k is accepted on cycle k+1.
- Throughput (base): one word per SPLIT_NUM+1 cycles; a 1-cycle bubble in IDLE between words.
- busy=1 whenever state==SEND or the holding buffer is full.
- idx wraps only via the last-chunk transition; it never exceeds SPLIT_NUM-1.
- Base build: din_ready=0 throughout SEND.
- Downstream stall (dout_ready=0 for any number of cycles): no state change, no data loss.

Optional Feature:
SPLIT_PREFETCH_EN
- Defined:
  - Adds a one-word holding buffer; din_ready = ~buf_full, so a word is accepted during SEND.
  - On the last-chunk handshake with buf_full: load the buffer into the word register, idx<=0, stay in SEND. No bubble; steady-state throughput is one word per SPLIT_NUM cycles.
  - Simultaneous din handshake and last-chunk handshake with buffer empty: incoming word goes straight to the word register, state stays SEND.
  - Simultaneous din handshake and last-chunk handshake with buffer full: the buffer drains to the word register and the new word fills the buffer. This case cannot occur in practice, because din_ready=0 while buf_full.
  - Reset clears buf_full.
- Undefined: no buffer; behaviour exactly as the base FSM above.

Test Plan:
- Reset, then din=32'hDEADBEEF with 1-cycle din_valid and dout_ready=1 -> dout sequence EF,BE,AD,DE on 4 consecutive cycles starting 1 cycle after the accept; then dout_valid=0, din_ready=1, busy=0.
- Same word, dout_ready toggled 1,0,0,1,0,1,1 -> dout stays stable while stalled; exactly 4 chunks EF,BE,AD,DE delivered, none duplicated.
- Back-to-back words 32'h03020100 and 32'h07060504 with din_valid held high -> chunks 00..07 in order.
  - Base: one bubble cycle between words.
  - SPLIT_PREFETCH_EN: no bubble; din_ready low only while the buffer is full.
- rst driven low after the 2nd chunk of 32'h11223344, then released -> dout_valid=0 and dout=0 on the cycle after reset; no further chunks; a new word 32'hA5A5A5A5 then splits normally.
- din_valid pulsed while din_ready=0 (base build, mid-word) -> pulse ignored; the current word completes unchanged.
- Loopback: split output fed into the concat receive block, 100 random words -> every reassembled word equals its source.
